// File: rtl/mrd_src_pkg.sv
// mrd_src_pkg: shared FSM codes, state type and small-constant arithmetic
// for the mrd Source-phase sequencer.
package mrd_src_pkg;
    localparam logic [2:0] FSM_IDLE   = 3'd0;
    localparam logic [2:0] FSM_LOAD   = 3'd1;
    localparam logic [2:0] FSM_FWD    = 3'd2;
    localparam logic [2:0] FSM_TWID   = 3'd3;
    localparam logic [2:0] FSM_BWD    = 3'd4;
    localparam logic [2:0] FSM_SOURCE = 3'd5;

    typedef enum logic [2:0] {IDLE, WAIT, RUN, DRAIN, DONE} src_state_t;
    typedef logic [2:0] radix_t;

    function automatic radix_t eff_radix(input radix_t r);
        return (r <= 3'd1) ? 3'd1 : r;
    endfunction

    // Shift-add multiply by a constant of at most 7.
    function automatic logic [31:0] mul_small(input logic [31:0] x, input logic [2:0] r);
        return (r[0] ? x : 32'd0) + (r[1] ? x << 1 : 32'd0) + (r[2] ? x << 2 : 32'd0);
    endfunction
endpackage

// File: rtl/mrd_radix_weight_calc.sv
// mrd_radix_weight_calc: computes digit weights W, product P and lane offsets LO,
// one radix stage per cycle after a start pulse; done stays high until the next start.
module mrd_radix_weight_calc import mrd_src_pkg::*; #(
    parameter int AW     = 12,
    parameter int NLANE  = 2,
    parameter int NSTAGE = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          start,
    input  radix_t        Nf [0:NSTAGE-1],
    output logic [AW-1:0] w  [0:NSTAGE-1],
    output logic [AW-1:0] p,
    output logic [AW-1:0] lo [0:NLANE-1],
    output logic          done
);
    localparam int KW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

    logic          busy_q, busy_d, done_q, done_d;
    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] w_q [0:NSTAGE-1], w_d [0:NSTAGE-1];
    logic [AW-1:0] lo_q [0:NLANE-1], lo_d [0:NLANE-1];
    logic [AW-1:0] p_q, p_d, nxt;

    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        k_d    = k_q;
        w_d    = w_q;
        p_d    = p_q;
        lo_d   = lo_q;
        nxt    = AW'(mul_small(32'(w_q[k_q]), eff_radix(Nf[k_q])));
        if (en && start) begin
            busy_d           = 1'b1;
            done_d           = 1'b0;
            k_d              = KW'(NSTAGE - 1);
            w_d[NSTAGE-1]    = AW'(1);
        end else if (en && busy_q) begin
            if (k_q == '0) begin
                p_d    = nxt;
                for (int l = 0; l < NLANE; l++) lo_d[l] = AW'(mul_small(32'(w_q[0]), 3'(l)));
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                w_d[k_q - 1'b1] = nxt;
                k_d             = k_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            k_q    <= '0;
            p_q    <= '0;
            for (int i = 0; i < NSTAGE; i++) w_q[i] <= '0;
            for (int l = 0; l < NLANE; l++) lo_q[l] <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            k_q    <= k_d;
            p_q    <= p_d;
            w_q    <= w_d;
            lo_q   <= lo_d;
        end
    end

    assign w    = w_q;
    assign p    = p_q;
    assign lo   = lo_q;
    assign done = done_q;
endmodule

// File: rtl/mrd_source_seq_pn.sv
// mrd_source_seq_pn: Source-phase sequencer issuing digit-reversed RAM read addresses
// for NLANE points per beat, with a RAM-latency-matched sop/eop/valid shadow.
module mrd_source_seq_pn import mrd_src_pkg::*; #(
    parameter int         AW      = 12,
    parameter int         NLANE   = 2,
    parameter int         NSTAGE  = 6,
    parameter int         WAIT_ST = 8,
    parameter int         RD_LAT  = 8,
    parameter logic [2:0] FSM_SRC = FSM_SOURCE
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    fsm,
    input  radix_t        Nf [0:NSTAGE-1],
    input  logic [AW-1:0] dftpts,
    input  logic          hold,
    output logic [AW-1:0] addrs [0:NLANE-1],
    output logic          addr_valid,
    output logic          sop,
    output logic          eop,
    output logic          valid,
    output logic          valid_pre,
    output logic          source_end,
    output logic          cfg_err
);
    localparam int CW = $clog2((WAIT_ST > RD_LAT ? WAIT_ST : RD_LAT) + 1);

    src_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] bcnt_q, bcnt_d, base_q, base_d, nbeat, p;
    logic [2:0]    c_q [0:NSTAGE-1], c_d [0:NSTAGE-1];
    logic [AW-1:0] ps_q [0:NSTAGE-1], ps_d [0:NSTAGE-1], w [0:NSTAGE-1];
    logic [AW-1:0] lo [0:NLANE-1];
    logic [2:0]    dl_q [0:RD_LAT-1], dl_d [0:RD_LAT-1];
    logic          cfg_err_q, cfg_err_d, source_end_q, source_end_d, start, ready, err, cy;

    mrd_radix_weight_calc #(.AW(AW), .NLANE(NLANE), .NSTAGE(NSTAGE)) u_calc (
        .clk(clk), .rst_n(rst_n), .en(!hold), .start(start), .Nf(Nf),
        .w(w), .p(p), .lo(lo), .done(ready)
    );

    assign nbeat = dftpts / AW'(NLANE);
    assign err   = (p != dftpts) || (|(dftpts % AW'(NLANE))) ||
                   (|(eff_radix(Nf[0]) % 3'(NLANE))) || (dftpts == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bcnt_d       = bcnt_q;
        c_d          = c_q;
        ps_d         = ps_q;
        dl_d         = dl_q;
        cfg_err_d    = cfg_err_q;
        source_end_d = source_end_q;
        start        = 1'b0;
        cy           = 1'b1;
        base_d       = '0;
        if (!hold) begin
            dl_d[0] = '0;
            for (int i = 1; i < RD_LAT; i++) dl_d[i] = dl_q[i-1];
            if (state_q != RUN) begin
                for (int k = 0; k < NSTAGE; k++) begin
                    c_d[k]  = '0;
                    ps_d[k] = '0;
                end
            end
            case (state_q)
                IDLE: if (fsm == FSM_SRC) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
                WAIT: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WAIT_ST - 1) && ready) begin
                        state_d   = err ? DONE : RUN;
                        cfg_err_d = err;
                        cnt_d     = '0;
                        bcnt_d    = '0;
                    end
                end
                RUN: begin
                    dl_d[0] = {bcnt_q == '0, bcnt_q == nbeat - 1'b1, 1'b1};
                    bcnt_d  = bcnt_q + 1'b1;
                    // Odometer: digit 0 steps by NLANE, a wrap carries into the next digit.
                    for (int k = 0; k < NSTAGE; k++) begin
                        if (cy) begin
                            if ({1'b0, c_q[k]} + ((k == 0) ? 4'(NLANE) : 4'd1) >= {1'b0, eff_radix(Nf[k])}) begin
                                c_d[k]  = '0;
                                ps_d[k] = '0;
                            end else begin
                                c_d[k]  = c_q[k] + ((k == 0) ? 3'(NLANE) : 3'd1);
                                ps_d[k] = ps_q[k] + ((k == 0) ? w[0] + lo[NLANE-1] : w[k]);
                                cy      = 1'b0;
                            end
                        end
                    end
                    if (bcnt_q == nbeat - 1'b1) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
                DRAIN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(RD_LAT - 1)) state_d = DONE;
                end
                default: ;
            endcase
            source_end_d = (state_d == DONE) && (state_q != DONE);
        end
        if (fsm != FSM_SRC && state_q != IDLE) begin
            state_d      = IDLE;
            cfg_err_d    = 1'b0;
            source_end_d = 1'b0;
            for (int i = 0; i < RD_LAT; i++) dl_d[i] = '0;
        end
        for (int k = 0; k < NSTAGE; k++) base_d = base_d + ps_d[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bcnt_q       <= '0;
            base_q       <= '0;
            cfg_err_q    <= 1'b0;
            source_end_q <= 1'b0;
            for (int k = 0; k < NSTAGE; k++) begin
                c_q[k]  <= '0;
                ps_q[k] <= '0;
            end
            for (int i = 0; i < RD_LAT; i++) dl_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            base_q       <= base_d;
            cfg_err_q    <= cfg_err_d;
            source_end_q <= source_end_d;
            c_q          <= c_d;
            ps_q         <= ps_d;
            dl_q         <= dl_d;
        end
    end

    always_comb begin
        for (int l = 0; l < NLANE; l++) addrs[l] = (state_q == RUN) ? base_q + lo[l] : '0;
    end

    assign addr_valid = (state_q == RUN) && !hold;
    assign sop        = dl_q[RD_LAT-1][2];
    assign eop        = dl_q[RD_LAT-1][1];
    assign valid      = dl_q[RD_LAT-1][0];
    assign valid_pre  = dl_q[RD_LAT-2][0];
    assign source_end = source_end_q;
    assign cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_mrd_source_seq_pn.sv
// tb_mrd_source_seq_pn: directed scenarios on a 1-lane and a 2-lane instance sharing stimulus.
module tb_mrd_source_seq_pn;
    import mrd_src_pkg::*;
    localparam int AW = 12;

    logic          clk = 1'b0, rst_n = 1'b0, hold = 1'b0;
    logic [2:0]    fsm = 3'd0;
    radix_t        nf [0:5];
    logic [AW-1:0] dftpts = '0;
    logic [AW-1:0] a1 [0:0];
    logic [AW-1:0] a2 [0:1];
    logic          av1, s1, e1, v1, vp1, se1, ce1;
    logic          av2, s2, e2, v2, vp2, se2, ce2;
    int            pass_cnt = 0, total = 0;

    always #5 clk = ~clk;

    mrd_source_seq_pn #(.NLANE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .fsm(fsm), .Nf(nf), .dftpts(dftpts), .hold(hold),
        .addrs(a1), .addr_valid(av1), .sop(s1), .eop(e1), .valid(v1),
        .valid_pre(vp1), .source_end(se1), .cfg_err(ce1)
    );

    mrd_source_seq_pn #(.NLANE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .fsm(fsm), .Nf(nf), .dftpts(dftpts), .hold(hold),
        .addrs(a2), .addr_valid(av2), .sop(s2), .eop(e2), .valid(v2),
        .valid_pre(vp2), .source_end(se2), .cfg_err(ce2)
    );

    task automatic set_cfg(input int n0, input int n1, input int n2, input int pts);
        nf[0] = 3'(n0);
        nf[1] = 3'(n1);
        nf[2] = 3'(n2);
        for (int i = 3; i < 6; i++) nf[i] = 3'd1;
        dftpts = AW'(pts);
    endtask

    task automatic idle_cycles(input int n);
        fsm = 3'd0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_cfg(1, 1, 1, 0);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({av1, s1, e1, v1, vp1, se1, ce1} !== 7'b0 || a1[0] !== '0)
            $display("FAIL reset_u1 got ctl=%b addr=%0d want ctl=0 addr=0", {av1, s1, e1, v1, vp1, se1, ce1}, a1[0]);
        else pass_cnt++;
        total++;
        if ({av2, s2, e2, v2, vp2, se2, ce2} !== 7'b0 || a2[0] !== '0 || a2[1] !== '0)
            $display("FAIL reset_u2 got ctl=%b addr=(%0d,%0d) want all 0", {av2, s2, e2, v2, vp2, se2, ce2}, a2[0], a2[1]);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_scenario1(input string tag);
        int exp1 [12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
        int ai = 0, vi = 0, fb = -1, fv = -1, fvp = -1, nvp = 0, ec = -1, sc = -1, nse = 0, nce = 0;
        int sop_i = -1, eop_i = -1;
        set_cfg(3, 4, 1, 12);
        fsm = FSM_SOURCE;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            #1;
            if (av1) begin
                total++;
                if (ai >= 12 || a1[0] !== AW'(exp1[ai]))
                    $display("FAIL %s addr[%0d] got %0d want %0d", tag, ai, a1[0], (ai < 12) ? exp1[ai] : -1);
                else pass_cnt++;
                if (fb < 0) fb = c;
                ai++;
            end
            if (v1) begin
                if (fv < 0) fv = c;
                if (s1) sop_i = vi;
                if (e1) begin eop_i = vi; ec = c; end
                vi++;
            end
            if (vp1) begin if (fvp < 0) fvp = c; nvp++; end
            if (se1) begin nse++; sc = c; end
            if (ce1) nce++;
        end
        total++; if (ai !== 12) $display("FAIL %s beats got %0d want 12", tag, ai); else pass_cnt++;
        total++; if (vi !== 12) $display("FAIL %s valid_count got %0d want 12", tag, vi); else pass_cnt++;
        total++; if (sop_i !== 0) $display("FAIL %s sop_index got %0d want 0", tag, sop_i); else pass_cnt++;
        total++; if (eop_i !== 11) $display("FAIL %s eop_index got %0d want 11", tag, eop_i); else pass_cnt++;
        total++; if (fv - fb !== 8) $display("FAIL %s latency got %0d want 8", tag, fv - fb); else pass_cnt++;
        total++; if (fvp !== fv - 1 || nvp !== 12) $display("FAIL %s valid_pre got first=%0d n=%0d want first=%0d n=12", tag, fvp, nvp, fv - 1); else pass_cnt++;
        total++; if (nse !== 1 || sc !== ec + 1) $display("FAIL %s source_end got n=%0d at %0d want n=1 at %0d", tag, nse, sc, ec + 1); else pass_cnt++;
        total++; if (nce !== 0) $display("FAIL %s cfg_err got %0d cycles want 0", tag, nce); else pass_cnt++;
        idle_cycles(2);
    endtask

    task automatic test_lanes2(input string tag, input bit with_hold);
        int ea [6] = '{0, 2, 4, 1, 3, 5};
        int ai = 0, hc = 0, vi = 0, fb = -1, fv = -1, lv = -1, nse = 0, sc = -1, sop_i = -1, eop_i = -1;
        int extra = with_hold ? 3 : 0;
        set_cfg(2, 3, 2, 12);
        fsm = FSM_SOURCE;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            hold = with_hold && ai == 3 && hc < 3;
            if (hold) hc++;
            #1;
            if (hold) begin
                total++;
                if (av2 !== 1'b0) $display("FAIL %s hold_addr_valid got %b want 0", tag, av2); else pass_cnt++;
            end
            if (av2) begin
                total++;
                if (ai >= 6 || a2[0] !== AW'(ea[ai]) || a2[1] !== AW'(ea[ai] + 6))
                    $display("FAIL %s pair[%0d] got (%0d,%0d) want (%0d,%0d)", tag, ai, a2[0], a2[1],
                             (ai < 6) ? ea[ai] : -1, (ai < 6) ? ea[ai] + 6 : -1);
                else pass_cnt++;
                if (fb < 0) fb = c;
                ai++;
            end
            if (v2) begin
                if (fv < 0) fv = c;
                lv = c;
                if (s2) sop_i = vi;
                if (e2) eop_i = vi;
                vi++;
            end
            if (se2) begin nse++; sc = c; end
        end
        hold = 1'b0;
        total++; if (ai !== 6) $display("FAIL %s beats got %0d want 6", tag, ai); else pass_cnt++;
        total++; if (vi !== 6 || lv - fv + 1 !== 6) $display("FAIL %s valid got n=%0d span=%0d want 6/6", tag, vi, lv - fv + 1); else pass_cnt++;
        total++; if (fv - fb !== 8 + extra) $display("FAIL %s latency got %0d want %0d", tag, fv - fb, 8 + extra); else pass_cnt++;
        total++; if (lv - fb !== 13 + extra) $display("FAIL %s frame_span got %0d want %0d", tag, lv - fb, 13 + extra); else pass_cnt++;
        total++; if (sop_i !== 0 || eop_i !== 5) $display("FAIL %s sop_eop got %0d/%0d want 0/5", tag, sop_i, eop_i); else pass_cnt++;
        total++; if (nse !== 1 || sc !== lv + 1) $display("FAIL %s source_end got n=%0d at %0d want n=1 at %0d", tag, nse, sc, lv + 1); else pass_cnt++;
        idle_cycles(2);
    endtask

    task automatic test_cfg_err;
        int nav = 0, nv = 0, nse = 0;
        set_cfg(3, 4, 1, 16);
        fsm = FSM_SOURCE;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            nav += int'(av1);
            nv  += int'(v1);
            if (se1) begin
                nse++;
                total++;
                if (ce1 !== 1'b1) $display("FAIL cfg_err_at_end got %b want 1", ce1); else pass_cnt++;
            end
        end
        total++; if (nav !== 0 || nv !== 0) $display("FAIL cfg_err_no_beats got av=%0d valid=%0d want 0/0", nav, nv); else pass_cnt++;
        total++; if (nse !== 1) $display("FAIL cfg_err_source_end got %0d want 1", nse); else pass_cnt++;
        idle_cycles(1);
        total++; if (ce1 !== 1'b0) $display("FAIL cfg_err_clear got %b want 0", ce1); else pass_cnt++;
        idle_cycles(1);
    endtask

    task automatic test_abort;
        int ai = 0, ab = -1, nv = 0, ne = 0, nse = 0;
        set_cfg(3, 4, 1, 12);
        fsm = FSM_SOURCE;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ai == 3 && ab < 0) begin fsm = 3'd0; ab = c; end
            #1;
            if (av1) ai++;
            if (ab >= 0 && c == ab + 1) begin
                total++;
                if ({av1, s1, e1, v1, vp1, se1, ce1} !== 7'b0 || a1[0] !== '0)
                    $display("FAIL abort_outputs got ctl=%b addr=%0d want all 0", {av1, s1, e1, v1, vp1, se1, ce1}, a1[0]);
                else pass_cnt++;
            end
            if (ab >= 0 && c > ab) begin
                nv  += int'(v1);
                ne  += int'(e1);
                nse += int'(se1);
            end
        end
        total++; if (ab < 0) $display("FAIL abort_reached got no beat 3 want beat 3"); else pass_cnt++;
        total++; if (nv !== 0 || ne !== 0 || nse !== 0) $display("FAIL abort_quiet got valid=%0d eop=%0d source_end=%0d want 0/0/0", nv, ne, nse); else pass_cnt++;
        test_scenario1("restart");
    endtask

    task automatic test_reset_drain;
        int ai = 0, dc = 0;
        bit fired = 0;
        set_cfg(3, 4, 1, 12);
        fsm = FSM_SOURCE;
        for (int c = 0; c < 45 && !fired; c++) begin
            @(negedge clk);
            if (ai == 12) dc++;
            if (dc == 3) begin rst_n = 1'b0; fsm = 3'd0; fired = 1; end
            #1;
            if (av1) ai++;
            if (fired) begin
                total++;
                if (v1 !== 1'b1) $display("FAIL drain_valid_before_reset got %b want 1", v1); else pass_cnt++;
            end
        end
        total++; if (!fired) $display("FAIL drain_reached got beats=%0d want 12", ai); else pass_cnt++;
        @(negedge clk);
        #1;
        total++;
        if ({av1, s1, e1, v1, vp1, se1, ce1} !== 7'b0 || a1[0] !== '0)
            $display("FAIL drain_reset_outputs got ctl=%b addr=%0d want all 0", {av1, s1, e1, v1, vp1, se1, ce1}, a1[0]);
        else pass_cnt++;
        rst_n = 1'b1;
        idle_cycles(1);
        test_scenario1("after_reset");
    endtask

    initial begin
        test_reset();
        test_scenario1("scn1");
        test_lanes2("scn2", 1'b0);
        test_lanes2("scn3_hold", 1'b1);
        test_cfg_err();
        test_abort();
        test_reset_drain();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
